blink_rate_ctrl: RTL and testbench
==================================

# blink_rate_ctrl

Front-end control stage for the board LED blinker. Conditions the raw pushbuttons and slide switches, keeps the current blink-rate selection, and generates the half-period toggle strobe and LED level consumed by the LED pattern driver directly downstream. The downstream stage does no timing of its own; it only maps `LEVEL` onto `LEDG`/`LEDR`.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock frequency; sets the rate-table cycle counts.
- `DEBOUNCE_CYCLES`, 500_000: cycles a synchronised key must stay stable before it is accepted (10 ms at 50 MHz).

Ports (one clock; reset is asynchronous, active-low):
- `CLOCK_50` in 1: system clock.
- `RST_N` in 1: asynchronous active-low reset.
- `KEY` in 4: raw pushbuttons, active-low, asynchronous to `CLOCK_50`.
- `SW` in 10: raw slide switches, asynchronous.
- `TICK` out 1: one-cycle strobe at each half-period boundary.
- `LEVEL` out 1: blink level; toggles in the cycle after `TICK`.
- `RATE_IDX` out 4: current rate index, 0..9.
- `PAUSED` out 1: high while blinking is frozen.

## Operation
- Every `KEY` bit passes through a 2-FF synchroniser, then a debouncer.
  - The debounced value changes only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A press is a debounced 1→0 transition and produces a one-cycle `press[i]`.
- `SW` passes through a 2-FF synchroniser only; it is not debounced.
- Rate table, as half-period in sixteenths of a second, indexed 0..9: 64, 48, 32, 24, 16, 12, 8, 4, 2, 1 (4 s down to 62.5 ms).
  - Half-period cycles are `RATE_MULT[idx] * (CLK_HZ/16)`.
- Key functions:
  - `KEY[0]`: toggle `PAUSED`.
  - `KEY[1]`: slower. `RATE_IDX` decrements, saturating at 0.
  - `KEY[2]`: faster. `RATE_IDX` increments, saturating at 9.
  - `KEY[3]`: load from switches (see Configuration).
- Simultaneous presses in one cycle:
  - `KEY[3]` has priority over `KEY[0]`, which has priority over `KEY[1]`/`KEY[2]`. Only the highest-priority action takes effect.
  - If `KEY[1]` and `KEY[2]` arrive together with no higher-priority press, there is no change.
- Half-period counter:
  - Counts 0..N-1. At N-1 it asserts `TICK` and wraps to 0.
  - Any change of `RATE_IDX` clears the counter to 0 in the same update cycle. This guarantees a full new half-period and no overshoot.
  - A press that leaves `RATE_IDX` unchanged (saturation) does not clear the counter.
- While `PAUSED`=1:
  - The counter holds and `TICK`=0.
  - `LEVEL` holds its value.
  - Rate changes still update `RATE_IDX` and clear the counter.
  - Un-pausing resumes from the held count.
- Reset values: `TICK`=0, `LEVEL`=0, `RATE_IDX`=4 (1 s), `PAUSED`=0, counter=0, debounced keys=1 (released), synchroniser flops=1.
- Reset asserted mid-count or mid-debounce discards all state. There is no spurious press on release of reset, even if a key is held.

## Timing
- Raw `KEY` edge at cycle t, held stable:
  - Debounced edge and `press` occur at t+2+`DEBOUNCE_CYCLES`.
  - The registered `RATE_IDX`/`PAUSED` update is visible one cycle later.
- `TICK` is registered: high exactly one cycle, every N cycles while running. `LEVEL` flips in the following cycle.
- Counter width: `CNT_W = $clog2(4*CLK_HZ)`, which is 28 at 50 MHz. All compares are unsigned at `CNT_W`.

## Configuration
- `BLINK_SW_LOAD_EN` defined:
  - `KEY[3]` press loads `RATE_IDX` from the highest set bit of synchronised `SW` (bit i maps to index i).
  - If `SW` is all zero, `RATE_IDX` keeps its value.
  - The load follows the counter-clear rule.
- `BLINK_SW_LOAD_EN` undefined:
  - `SW` and its synchroniser are not built, and `KEY[3]` has no effect.
  - The `KEY[3]` debouncer is still instantiated, so the press priority rule above is unchanged.

## Structure
- Package `blink_pkg` holds:
  - `NUM_RATES`=10.
  - `RATE_MULT[0:9]` constant array.
  - `rate_idx_t` (4-bit).
  - `RESET_RATE`=4.
  - A function returning the cycle count for an index given `CLK_HZ`.
- One sub-module, `key_debounce`: synchroniser plus debounce counter plus press pulse, parameterised by `DEBOUNCE_CYCLES`, instantiated four times.

## Test plan
All scenarios use `CLK_HZ`=16, so the table is 64..1 cycles, and `DEBOUNCE_CYCLES`=4.
- Reset, then run 40 cycles → `RATE_IDX`=4 and `TICK` pulses every 16 cycles; `LEVEL` reads 0,1,0 after successive ticks.
- `KEY[2]` held low 3 cycles, then released → no press and `RATE_IDX` stays 4. Held 10 cycles → exactly one press and `RATE_IDX`=5; `TICK` spacing becomes 12 cycles, counted from the update.
- Eleven `KEY[2]` presses from reset → `RATE_IDX` saturates at 9 with period 1 cycle (`TICK` high every cycle). Then 12 `KEY[1]` presses → saturates at 0 with period 64.
- `KEY[0]` press mid-count (counter=7) → `TICK` stops and `LEVEL` holds; a second press resumes, with the next `TICK` exactly 9 running cycles later.
- `KEY[1]` and `KEY[2]` pressed in the same cycle → `RATE_IDX` unchanged and counter not cleared. `KEY[0]` and `KEY[2]` together → only `PAUSED` toggles.
- With `BLINK_SW_LOAD_EN`: `SW`=10'b0010000100, `KEY[3]` press → `RATE_IDX`=7. `SW`=0, `KEY[3]` press → unchanged. Without the macro: the same stimulus leaves `RATE_IDX`=4. Reset asserted mid-debounce with a key held → no press after release.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants and helpers for the blink-rate control front end.
package blink_pkg;

  localparam int NUM_RATES = 10;

  typedef logic [3:0] rate_idx_t;

  localparam rate_idx_t RESET_RATE = 4'd4;

  // Half-period of each rate in sixteenths of a second, slowest first.
  localparam int unsigned RATE_MULT [0:NUM_RATES-1] = '{64, 48, 32, 24, 16, 12, 8, 4, 2, 1};

  function automatic int unsigned half_period_cycles(input rate_idx_t idx, input int unsigned clk_hz);
    int unsigned mult;
    mult = (int'(idx) < NUM_RATES) ? RATE_MULT[idx] : RATE_MULT[NUM_RATES-1];
    return mult * (clk_hz / 16);
  endfunction

  function automatic rate_idx_t highest_set(input logic [NUM_RATES-1:0] v);
    rate_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_RATES; i++) begin
      if (v[i]) idx = rate_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchroniser, stability counter, and a one-cycle pulse
// on each accepted release-to-press (1->0) transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync;
  logic            stable;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      // Any sample matching the accepted value restarts the stability window.
      if (sync[1] != stable) begin
        if (cnt == DB_LAST) begin
          stable <= sync[1];
          cnt    <= '0;
          press  <= stable;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// Key conditioning, rate selection and half-period TICK/LEVEL generation.
// Define BLINK_SW_LOAD_EN to let KEY[3] load the rate from the slide switches.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic       TICK,
  output logic       LEVEL,
  output logic [3:0] RATE_IDX,
  output logic       PAUSED
);

  localparam int CNT_W = $clog2(4 * CLK_HZ);

  logic [3:0]       press;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  rate_idx_t        rate_nxt;
  logic             paused_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk  (CLOCK_50),
      .rst_n(RST_N),
      .raw  (KEY[i]),
      .press(press[i])
    );
  end

`ifdef BLINK_SW_LOAD_EN
  logic [9:0] sw_meta;
  logic [9:0] sw_sync;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta <= '1;
      sw_sync <= '1;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end
`else
  logic unused_sw;
  assign unused_sw = ^SW;
`endif

  assign cnt_last = CNT_W'(half_period_cycles(RATE_IDX, CLK_HZ) - 32'd1);

  // Only the highest-priority press acts: KEY[3], then KEY[0], then KEY[1]/KEY[2].
  always_comb begin
    rate_nxt   = RATE_IDX;
    paused_nxt = PAUSED;
    if (press[3]) begin
`ifdef BLINK_SW_LOAD_EN
      if (sw_sync != '0) rate_nxt = highest_set(sw_sync);
`endif
    end else if (press[0]) begin
      paused_nxt = ~PAUSED;
    end else if (press[1] && !press[2]) begin
      if (RATE_IDX != '0) rate_nxt = RATE_IDX - 1'b1;
    end else if (press[2] && !press[1]) begin
      if (RATE_IDX != rate_idx_t'(NUM_RATES - 1)) rate_nxt = RATE_IDX + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      RATE_IDX <= RESET_RATE;
      PAUSED   <= 1'b0;
      cnt      <= '0;
      TICK     <= 1'b0;
      LEVEL    <= 1'b0;
    end else begin
      RATE_IDX <= rate_nxt;
      PAUSED   <= paused_nxt;
      LEVEL    <= LEVEL ^ TICK;
      // A real rate change restarts the half-period so the new rate never overshoots.
      if (rate_nxt != RATE_IDX) begin
        cnt  <= '0;
        TICK <= 1'b0;
      end else if (PAUSED) begin
        TICK <= 1'b0;
      end else if (cnt == cnt_last) begin
        cnt  <= '0;
        TICK <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        TICK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed bench for blink_rate_ctrl at CLK_HZ=16, DEBOUNCE_CYCLES=4.
module tb_blink_rate_ctrl;

`ifdef BLINK_SW_LOAD_EN
  localparam int LOAD_IDX = 7;
  localparam int UP_AFTER_LOAD = 8;
`else
  localparam int LOAD_IDX = 4;
  localparam int UP_AFTER_LOAD = 5;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [9:0] sw;
  logic       tick;
  logic       level;
  logic [3:0] rate_idx;
  logic       paused;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  int tick_cnt;

  blink_rate_ctrl #(
    .CLK_HZ         (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .RST_N   (rst_n),
    .KEY     (key),
    .SW      (sw),
    .TICK    (tick),
    .LEVEL   (level),
    .RATE_IDX(rate_idx),
    .PAUSED  (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges until TICK is seen high; -1 if the budget runs out.
  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    do begin
      clk1();
      cycles++;
    end while (tick !== 1'b1 && cycles < budget);
    if (tick !== 1'b1) cycles = -1;
  endtask

  task automatic press_key(input logic [3:0] mask);
    key = 4'hf & ~mask;
    repeat (10) clk1();
    key = 4'hf;
    repeat (10) clk1();
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'hf;
    sw    = '0;

    // Reset values and free-running at rate 4 (16-cycle half period)
    repeat (3) clk1();
    check("reset_rate", 32'(rate_idx), 32'd4);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_paused", 32'(paused), 32'd0);
    rst_n = 1'b1;
    wait_tick(40, n);
    check("first_tick_gap", n, 16);
    clk1();
    check("tick_one_cycle", 32'(tick), 32'd0);
    check("level_after_tick1", 32'(level), 32'd1);
    wait_tick(40, n);
    check("second_tick_gap", n, 15);
    clk1();
    check("level_after_tick2", 32'(level), 32'd0);

    // Short glitch on KEY[2] is rejected
    key = 4'b1011;
    repeat (3) clk1();
    key = 4'hf;
    repeat (12) clk1();
    check("glitch_no_press", 32'(rate_idx), 32'd4);

    // Held KEY[2]: update lands 7 edges after the raw edge
    key = 4'b1011;
    repeat (6) clk1();
    check("faster_not_yet", 32'(rate_idx), 32'd4);
    clk1();
    check("faster_rate", 32'(rate_idx), 32'd5);
    wait_tick(40, n);
    check("rate5_first_gap", n, 12);
    key = 4'hf;
    repeat (12) clk1();
    wait_tick(40, n);
    wait_tick(40, n);
    check("rate5_gap", n, 12);
    check("one_press_only", 32'(rate_idx), 32'd5);

    // Saturation at both ends
    rst_n = 1'b0;
    repeat (2) clk1();
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) press_key(4'b0100);
    check("sat_high_rate", 32'(rate_idx), 32'd9);
    wait_tick(5, n);
    check("rate9_gap_a", n, 1);
    wait_tick(5, n);
    check("rate9_gap_b", n, 1);
    for (int i = 0; i < 12; i++) press_key(4'b0010);
    check("sat_low_rate", 32'(rate_idx), 32'd0);
    wait_tick(100, n);
    wait_tick(100, n);
    check("rate0_gap", n, 64);
    press_key(4'b0010);
    wait_tick(100, n);
    check("sat_press_no_clear", n, 44);

    // Pause with the counter at 7, resume 9 running cycles before the tick
    rst_n = 1'b0;
    repeat (2) clk1();
    rst_n = 1'b1;
    key   = 4'b1110;
    repeat (6) clk1();
    check("pause_not_yet", 32'(paused), 32'd0);
    clk1();
    check("pause_set", 32'(paused), 32'd1);
    tick_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) key = 4'hf;
      clk1();
      if (tick === 1'b1) tick_cnt++;
    end
    check("paused_no_tick", tick_cnt, 0);
    check("paused_level_hold", 32'(level), 32'd0);
    key = 4'b1110;
    repeat (7) clk1();
    check("pause_clear", 32'(paused), 32'd0);
    wait_tick(40, n);
    check("resume_gap", n, 9);
    key = 4'hf;
    repeat (12) clk1();

    // KEY[1]+KEY[2] together: no change, counter keeps running
    wait_tick(40, n);
    key = 4'b1001;
    repeat (10) clk1();
    key = 4'hf;
    wait_tick(40, n);
    check("both_dir_gap", n, 6);
    check("both_dir_rate", 32'(rate_idx), 32'd4);

    // KEY[0]+KEY[2] together: only pause toggles
    key = 4'b1010;
    repeat (7) clk1();
    check("pause_wins_paused", 32'(paused), 32'd1);
    check("pause_wins_rate", 32'(rate_idx), 32'd4);
    key = 4'hf;
    repeat (12) clk1();
    press_key(4'b0001);
    check("unpause", 32'(paused), 32'd0);

    // Switch load via KEY[3]
    sw = 10'b0010000100;
    press_key(4'b1000);
    check("sw_load", 32'(rate_idx), 32'(LOAD_IDX));
    sw = '0;
    press_key(4'b1000);
    check("sw_zero_keep", 32'(rate_idx), 32'(LOAD_IDX));
    press_key(4'b1001);
    check("key3_over_key0", 32'(paused), 32'd0);

    // Reset mid-debounce discards the pending press and the rate
    press_key(4'b0100);
    check("pre_reset_rate", 32'(rate_idx), 32'(UP_AFTER_LOAD));
    key = 4'b1011;
    repeat (4) clk1();
    rst_n = 1'b0;
    clk1();
    key = 4'hf;
    clk1();
    check("in_reset_rate", 32'(rate_idx), 32'd4);
    rst_n = 1'b1;
    repeat (15) clk1();
    check("post_reset_rate", 32'(rate_idx), 32'd4);
    check("post_reset_paused", 32'(paused), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
